// File: rtl/core_pkg.sv
// Core-wide types shared by the hart and its MMIO peripherals.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEM_WIDTH_BYTE,
        MEM_WIDTH_HALF,
        MEM_WIDTH_WORD
    } mem_width_t;

    typedef struct packed {
        logic             enable;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  value;
        mem_width_t       width;
    } mem_write_control_t;

endpackage

// File: rtl/mmio_uart_pkg.sv
// Register map, status bit positions and transmitter states for the MMIO UART.
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_tx_state_t;

    localparam logic [31:0] UART_TXDATA_OFFSET = 32'd0;
    localparam logic [31:0] UART_STATUS_OFFSET = 32'd4;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_MSB = 15;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Hart-side MMIO store path into the UART: store request in, completion pulse and STATUS word out.
interface mmio_uart_tx_if;
    import core_pkg::*;

    mem_write_control_t memory_mapped_io_control;
    logic               memory_mapped_io_write_complete;
    logic [XLEN-1:0]    memory_mapped_io_r_data;

    modport master (
        output memory_mapped_io_control,
        input  memory_mapped_io_write_complete,
        input  memory_mapped_io_r_data
    );

    modport slave (
        input  memory_mapped_io_control,
        output memory_mapped_io_write_complete,
        output memory_mapped_io_r_data
    );

endinterface

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Byte FIFO with registered occupancy count; head entry is visible combinationally on pop_data.
module byte_fifo #(
    parameter int depth = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [7:0]    mem [depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(depth));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap on natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: store handshake into a byte FIFO, 8N1 serialiser, registered STATUS word.
//   state      | meaning
//   UART_IDLE  | line high; pops the next byte when the FIFO holds one
//   UART_START | start bit (low) for clks_per_bit cycles
//   UART_DATA  | eight data bits, LSB first
//   UART_STOP  | stop bit (high) for clks_per_bit cycles
module mmio_uart_tx
    import core_pkg::*;
    import mmio_uart_pkg::*;
#(
    parameter logic [XLEN-1:0] base_addr    = 32'h0003_0000,
    parameter int              clks_per_bit = 434,
    parameter int              fifo_depth   = 4
) (
    input  logic           clock,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           uart_tx
);

    localparam int CW = $clog2(fifo_depth) + 1;
    localparam int BW = $clog2(clks_per_bit);
    localparam logic [BW-1:0] BAUD_LAST = BW'(clks_per_bit - 1);

    uart_tx_state_t  state, state_next;
    logic [BW-1:0]   baud, baud_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift, shift_next;
    logic            tx_next;
    logic            bit_done;

    logic            accepted;
    logic            write_complete;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] status_next;
    logic            request;
    logic            is_txdata;
    logic            push;
    logic            accept;
    logic            pop;

    logic [7:0]      pop_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            unused_ctrl_bits;

    byte_fifo #(.depth(fifo_depth)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.memory_mapped_io_control.value[7:0]),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // accepted blocks a second push while the hart still holds enable through the complete cycle.
    assign request   = bus.memory_mapped_io_control.enable && !accepted;
    assign is_txdata = (bus.memory_mapped_io_control.addr == base_addr + UART_TXDATA_OFFSET);
    assign push      = request && is_txdata && !fifo_full;
    assign accept    = request && (!is_txdata || !fifo_full);

    assign unused_ctrl_bits = ^{bus.memory_mapped_io_control.width,
                                bus.memory_mapped_io_control.value[XLEN-1:8]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accepted       <= 1'b0;
            write_complete <= 1'b0;
            r_data         <= '0;
        end else begin
            if (!bus.memory_mapped_io_control.enable) accepted <= 1'b0;
            else if (accept)                          accepted <= 1'b1;
            write_complete <= accept;
            r_data         <= status_next;
        end
    end

    always_comb begin
        status_next = '0;
        status_next[STATUS_BUSY_BIT]  = (state != UART_IDLE);
        status_next[STATUS_FULL_BIT]  = fifo_full;
        status_next[STATUS_EMPTY_BIT] = fifo_empty;
        status_next[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
    end

    assign bus.memory_mapped_io_write_complete = write_complete;
    assign bus.memory_mapped_io_r_data         = r_data;

    assign bit_done = (baud == BAUD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= UART_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

    // tx_next is the line level for the coming cycle, so uart_tx comes straight off a flop.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;
        pop        = 1'b0;
        unique case (state)
            UART_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = pop_data;
                    state_next = UART_START;
                    tx_next    = 1'b0;
                end
            end
            UART_START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = UART_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            UART_DATA: begin
                tx_next = shift[0];
                if (bit_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = UART_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shift[1];
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    state_next = UART_IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: begin
                state_next = UART_IDLE;
            end
        endcase
    end

endmodule
